// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared defaults, FSM state type and parity helper for the RAM responder
package ram_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 6;
    localparam int DEPTH_DEF  = 64;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Even parity over a zero-extended word; callers pad narrower data.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - DEPTH x WORD_W storage, one synchronous write port, one registered read port
module ram_array #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value between reads; a same-edge write is not visible here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - CPU data-memory responder with clear sweep, drop flag and write-first forwarding
// Optional: define RAM_PARITY_EN to store and check an even-parity bit per word.
module ram_responder
    import ram_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ram_write,
    input  logic              ram_read,
    input  logic [ADDR_W-1:0] ram_write_addr,
    input  logic [ADDR_W-1:0] ram_read_addr,
    input  logic [DATA_W-1:0] ram_data_in,
    output logic [DATA_W-1:0] ram_data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              req_dropped,
    output logic              parity_err
);

`ifdef RAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] clr_cnt;
    logic              busy_int;
    logic              rd_accept;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [WORD_W-1:0] arr_wdata;
    logic [WORD_W-1:0] arr_rdata;
    logic [WORD_W-1:0] din_word;
    logic              fwd_sel_q;
    logic [DATA_W-1:0] fwd_data_q;

`ifdef RAM_PARITY_EN
    assign din_word = {even_parity({{(64-DATA_W){1'b0}}, ram_data_in}), ram_data_in};
`else
    assign din_word = ram_data_in;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clr_cnt == LAST_ADDR) state_d = READY;
            READY:   state_d = READY;
            default: state_d = READY;
        endcase
    end

    // The sweep owns the write port while clearing; CPU writes are locked out.
    always_comb begin
        busy_int  = 1'b0;
        arr_we    = 1'b0;
        arr_waddr = ram_write_addr;
        arr_wdata = din_word;
        case (state_q)
            CLEAR: begin
                busy_int  = 1'b1;
                arr_we    = 1'b1;
                arr_waddr = clr_cnt;
                arr_wdata = '0;
            end
            READY: begin
                arr_we = ram_write;
            end
            default: begin
                busy_int = 1'b0;
            end
        endcase
    end

    assign busy      = busy_int;
    assign rd_accept = ram_read & ~busy_int;

    always_ff @(posedge clk) begin
        if (!reset) begin
            clr_cnt <= '0;
        end else if (state_q == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid    <= 1'b0;
            fwd_sel_q   <= 1'b0;
            fwd_data_q  <= '0;
            req_dropped <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                fwd_sel_q  <= ram_write && (ram_write_addr == ram_read_addr);
                fwd_data_q <= ram_data_in;
            end
            if (busy_int && (ram_read || ram_write)) begin
                req_dropped <= 1'b1;
            end
        end
    end

    ram_array #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (rd_accept),
        .raddr (ram_read_addr),
        .rdata (arr_rdata)
    );

    assign ram_data_out = fwd_sel_q ? fwd_data_q : arr_rdata[DATA_W-1:0];

`ifdef RAM_PARITY_EN
    // Forwarded data was never stored, so only array reads are checked.
    assign parity_err = rd_valid & ~fwd_sel_q &
                        (even_parity({{(64-DATA_W){1'b0}}, arr_rdata[DATA_W-1:0]}) != arr_rdata[DATA_W]);
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - directed self-checking bench for ram_responder
module tb_ram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        ram_write;
    logic        ram_read;
    logic [5:0]  ram_write_addr;
    logic [5:0]  ram_read_addr;
    logic [15:0] ram_data_in;
    logic [15:0] ram_data_out;
    logic        rd_valid;
    logic        busy;
    logic        req_dropped;
    logic        parity_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n;

    always #5 clk = ~clk;

    ram_responder dut (
        .clk            (clk),
        .reset          (reset),
        .ram_write      (ram_write),
        .ram_read       (ram_read),
        .ram_write_addr (ram_write_addr),
        .ram_read_addr  (ram_read_addr),
        .ram_data_in    (ram_data_in),
        .ram_data_out   (ram_data_out),
        .rd_valid       (rd_valid),
        .busy           (busy),
        .req_dropped    (req_dropped),
        .parity_err     (parity_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one request cycle from a negedge; returns at the next negedge with inputs idle.
    task automatic cycle_req(input logic wr, input logic [5:0] wa, input logic [15:0] wd,
                             input logic rd, input logic [5:0] ra);
        ram_write      = wr;
        ram_write_addr = wa;
        ram_data_in    = wd;
        ram_read       = rd;
        ram_read_addr  = ra;
        @(negedge clk);
        ram_write = 1'b0;
        ram_read  = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [5:0] ra, input logic [15:0] exp);
        cycle_req(1'b0, 6'h00, 16'h0000, 1'b1, ra);
        check({tag, "_data"}, 32'(ram_data_out), 32'(exp));
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_perr"}, 32'(parity_err), 32'd0);
    endtask

    // Counts busy samples from the current negedge; optionally pulses a write at drop_at.
    task automatic measure_sweep(output int cnt, input int drop_at);
        cnt = 0;
        while (busy && cnt < 200) begin
            if (cnt == drop_at) begin
                ram_write      = 1'b1;
                ram_write_addr = 6'h05;
                ram_data_in    = 16'hBEEF;
            end else begin
                ram_write = 1'b0;
            end
            cnt++;
            @(negedge clk);
        end
        ram_write = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; ram_write = 1'b0; ram_read = 1'b0;
        ram_write_addr = '0; ram_read_addr = '0; ram_data_in = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", 32'(ram_data_out), 32'd0);
        check("rst_dropped", 32'(req_dropped), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_perr", 32'(parity_err), 32'd0);

        reset = 1'b1;
        measure_sweep(n, 10);
        check("sweep_len", 32'(n), 32'd64);
        check("dropped_set", 32'(req_dropped), 32'd1);

        do_read("rd00", 6'h00, 16'h0000);
        do_read("rd1f", 6'h1F, 16'h0000);
        do_read("rd3f", 6'h3F, 16'h0000);
        do_read("rd05_dropped_wr", 6'h05, 16'h0000);
        @(negedge clk);
        check("idle_valid", 32'(rd_valid), 32'd0);

        // Write at edge N, read at edge N+1, data valid only in cycle N+2.
        cycle_req(1'b1, 6'h12, 16'hA5A5, 1'b0, 6'h00);
        check("wr12_no_valid", 32'(rd_valid), 32'd0);
        do_read("rd12", 6'h12, 16'hA5A5);
        @(negedge clk);
        check("rd12_valid_drop", 32'(rd_valid), 32'd0);
        check("rd12_hold", 32'(ram_data_out), 32'h0000A5A5);

        cycle_req(1'b1, 6'h07, 16'h1234, 1'b1, 6'h07);
        check("wf07_data", 32'(ram_data_out), 32'h00001234);
        check("wf07_valid", 32'(rd_valid), 32'd1);

        cycle_req(1'b1, 6'h09, 16'h00FF, 1'b0, 6'h00);
        cycle_req(1'b1, 6'h08, 16'h5555, 1'b1, 6'h09);
        check("diff09_data", 32'(ram_data_out), 32'h000000FF);
        check("diff09_valid", 32'(rd_valid), 32'd1);
        do_read("rd08", 6'h08, 16'h5555);
        do_read("b2b07", 6'h07, 16'h1234);
        do_read("b2b12", 6'h12, 16'hA5A5);

        // Reset arriving with a read pending cancels the read.
        ram_read = 1'b1; ram_read_addr = 6'h12; reset = 1'b0;
        @(negedge clk);
        check("rstrd_valid", 32'(rd_valid), 32'd0);
        check("rstrd_busy", 32'(busy), 32'd1);
        check("rstrd_dropped", 32'(req_dropped), 32'd0);
        ram_read = 1'b0; reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ram_read = (i == 5);
            @(negedge clk);
        end
        ram_read = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_dropped", 32'(req_dropped), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("rst2_dropped", 32'(req_dropped), 32'd0);
        reset = 1'b1;
        measure_sweep(n, -1);
        check("sweep2_len", 32'(n), 32'd64);
        do_read("rd12_swept", 6'h12, 16'h0000);
        do_read("rd08_swept", 6'h08, 16'h0000);

`ifdef RAM_PARITY_EN
        cycle_req(1'b1, 6'h03, 16'h0001, 1'b0, 6'h00);
        dut.u_array.mem[3][16] = 1'b0;
        cycle_req(1'b0, 6'h00, 16'h0000, 1'b1, 6'h03);
        check("par03_valid", 32'(rd_valid), 32'd1);
        check("par03_err", 32'(parity_err), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Data-memory responder on the memory side of the CPU's RAM request interface.
- Receives ram_read/ram_write strobes, 6-bit addresses and 16-bit write data from the CPU.
- Returns read data with fixed 1-cycle latency.
- Runs a post-reset clear sweep, flags requests dropped while busy, and resolves same-cycle read/write collisions deterministically.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 6, address width
- DEPTH, 64, number of words; must equal 2**ADDR_W
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = skip sweep, contents undefined

Ports:
- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
- ram_write  input  1  write strobe, one request per cycle high
- ram_read  input  1  read strobe, one request per cycle high
- ram_write_addr  input  ADDR_W  write address
- ram_read_addr  input  ADDR_W  read address
- ram_data_in  input  DATA_W  write data
- ram_data_out  output  DATA_W  read data, registered
- rd_valid  output  1  one-cycle pulse: ram_data_out holds a fresh read result
- busy  output  1  high while clearing; requests not accepted
- req_dropped  output  1  sticky: a request arrived while busy; cleared only by reset
- parity_err  output  1  read parity error pulse (see Optional Feature)

Behaviour:
- Reset (reset=0 at posedge):
  - State goes to CLEAR if CLEAR_ON_RESET=1, else READY.
  - clr_cnt=0, ram_data_out=0, rd_valid=0, req_dropped=0, parity_err=0.
  - busy=1 if CLEAR_ON_RESET, else 0.
  - Reset mid-read cancels the pending rd_valid.
  - Reset mid-clear restarts the sweep from 0.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes 0 to mem[clr_cnt], then increments clr_cnt.
  - On the clr_cnt==DEPTH-1 write, next state is READY and busy drops to 0 on the following cycle.
  - Sweep is exactly DEPTH cycles: busy high for cycles 1..64 after reset release.
- Requests while busy:
  - ram_read or ram_write high while busy: request ignored, memory unchanged, no rd_valid.
  - req_dropped set to 1 and held.
- READY, write: ram_write=1 at edge N gives mem[ram_write_addr] <= ram_data_in at edge N.
- READY, read:
  - ram_read=1 at edge N gives ram_data_out = mem[ram_read_addr] and rd_valid=1 after edge N.
  - Result is visible during cycle N+1; latency is 1.
  - rd_valid is high exactly one cycle per read; back-to-back reads give a continuous rd_valid.
- Between reads, ram_data_out holds its last value and rd_valid=0.
- Simultaneous read and write:
  - Same address: write-first; read returns ram_data_in of the same cycle.
  - Different addresses: both complete independently.
- Address width is exact (DEPTH=2**ADDR_W), so there is no out-of-range case and no wrap logic.
- No back-pressure; the CPU may issue one read and one write every READY cycle.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on write; the clear sweep writes parity 0.
  - On each read, recomputed parity is compared with the stored bit.
  - parity_err pulses with rd_valid on mismatch.
  - Write-first forwarded reads use freshly computed parity and never flag.
  - Storage is DATA_W+1 bits.
- Undefined: no parity storage; parity_err tied to 0.

Decomposition:
- Package ram_pkg:
  - DATA_W/ADDR_W/DEPTH defaults
  - state typedef (CLEAR, READY)
  - parity function
- Sub-module ram_array: DEPTH x (DATA_W[+1]) storage, one synchronous write port, one registered read port.
- ram_responder owns the FSM, clr_cnt, collision forwarding, req_dropped and rd_valid.

Test Plan:
- Reset low 2 cycles, then high.
  - busy=1 for 64 cycles, then 0.
  - Read addr 0x00, 0x1F and 0x3F: each returns 0x0000 with a 1-cycle rd_valid.
- During clear, pulse ram_write addr 0x05 data 0xBEEF.
  - req_dropped=1.
  - After clear, read 0x05 returns 0x0000.
- READY: write 0x12 <= 0xA5A5 at edge N, read 0x12 at edge N+1.
  - ram_data_out=0xA5A5 with rd_valid=1 in cycle N+2 only.
- Same cycle: write 0x07 <= 0x1234 and read 0x07.
  - Next cycle ram_data_out=0x1234 (write-first).
- Same cycle: write 0x08 <= 0x5555 and read 0x09 (previously 0x00FF).
  - ram_data_out=0x00FF.
  - A later read of 0x08 returns 0x5555.
- Reset asserted at clear count 30 and mid-read.
  - rd_valid stays 0, sweep restarts, busy high for a full 64 cycles, req_dropped cleared.
  - With RAM_PARITY_EN, force the stored parity bit of word 0x03: the read gives parity_err=1 with rd_valid.
